// File: rtl/tail_light_scheduler.sv
// Tail-light scheduler: request arbitration, phase timebase and LED drive.
// Optional COMFORT_BLINK_EN holds LEFT/RIGHT for three full pattern wraps.
module tail_light_scheduler #(
   parameter int TICK_DIV    = 25000000,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       sw_hazard,
   input  logic       sw_left,
   input  logic       sw_brake,
   input  logic       key_right_n,
   output logic [9:0] LEDR,
   output logic [2:0] mode,
   output logic [1:0] phase,
   output logic       busy
);

   localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   localparam logic [2:0] M_IDLE   = 3'd0;
   localparam logic [2:0] M_LEFT   = 3'd1;
   localparam logic [2:0] M_RIGHT  = 3'd2;
   localparam logic [2:0] M_HAZARD = 3'd3;
   localparam logic [2:0] M_BRAKE  = 3'd4;
   localparam logic [2:0] M_BLEFT  = 3'd5;
   localparam logic [2:0] M_BRIGHT = 3'd6;

   logic [SYNC_STAGES-1:0] r_sync_h;
   logic [SYNC_STAGES-1:0] r_sync_l;
   logic [SYNC_STAGES-1:0] r_sync_b;
   logic [SYNC_STAGES-1:0] r_sync_r;

   logic [CW-1:0] r_cnt;
   logic [2:0]    r_mode;
   logic [1:0]    r_phase;
   logic          r_busy;
   logic [9:0]    r_ledr;

   logic          w_h;
   logic          w_l;
   logic          w_b;
   logic          w_r;
   logic          w_tick;
   logic [2:0]    w_req;
   logic [2:0]    w_mode_nx;
   logic [1:0]    w_phase_nx;
   logic [9:0]    w_led_nx;
   logic [2:0]    w_lpat;
   logic [2:0]    w_rpat;

   // Right request is kept active-high in its chain so a cleared chain
   // means "no request" coming out of reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sync_h <= '0;
         r_sync_l <= '0;
         r_sync_b <= '0;
         r_sync_r <= '0;
      end else begin
         r_sync_h <= {r_sync_h[SYNC_STAGES-2:0], sw_hazard};
         r_sync_l <= {r_sync_l[SYNC_STAGES-2:0], sw_left};
         r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], sw_brake};
         r_sync_r <= {r_sync_r[SYNC_STAGES-2:0], ~key_right_n};
      end
   end

   assign w_h = r_sync_h[SYNC_STAGES-1];
   assign w_l = r_sync_l[SYNC_STAGES-1];
   assign w_b = r_sync_b[SYNC_STAGES-1];
   assign w_r = r_sync_r[SYNC_STAGES-1];

   always_comb begin
      w_req = M_IDLE;
      if (w_h || (w_l && w_r))
         w_req = M_HAZARD;
      else if (w_l && w_b)
         w_req = M_BLEFT;
      else if (w_r && w_b)
         w_req = M_BRIGHT;
      else if (w_l)
         w_req = M_LEFT;
      else if (w_r)
         w_req = M_RIGHT;
      else if (w_b)
         w_req = M_BRAKE;
   end

   assign w_tick = (r_cnt == CW'(TICK_DIV - 1));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         r_cnt <= '0;
      else if (r_mode == M_IDLE || w_tick)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + CW'(1);
   end

`ifdef COMFORT_BLINK_EN
   logic [1:0] r_wraps;
   logic [1:0] w_wraps_nx;
   logic       w_hold;

   assign w_hold = (r_mode == M_LEFT || r_mode == M_RIGHT)
                && (w_req == M_IDLE)
                && (r_wraps != 2'd3)
                && !(r_wraps == 2'd2 && r_phase == 2'd3);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         r_wraps <= '0;
      else
         r_wraps <= w_wraps_nx;
   end
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_mode  <= M_IDLE;
         r_phase <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_mode  <= w_mode_nx;
         r_phase <= w_phase_nx;
         r_busy  <= (w_mode_nx != M_IDLE);
      end
   end

   always_comb begin
      w_mode_nx  = r_mode;
      w_phase_nx = r_phase;
`ifdef COMFORT_BLINK_EN
      w_wraps_nx = r_wraps;
`endif
      if (r_mode == M_IDLE) begin
         w_mode_nx  = w_req;
         w_phase_nx = 2'd0;
`ifdef COMFORT_BLINK_EN
         w_wraps_nx = 2'd0;
`endif
      end else if (w_tick) begin
`ifdef COMFORT_BLINK_EN
         if (w_req == r_mode || w_hold) begin
            w_phase_nx = r_phase + 2'd1;
            if (r_phase == 2'd3 && r_wraps != 2'd3)
               w_wraps_nx = r_wraps + 2'd1;
         end else begin
            w_mode_nx  = w_req;
            w_phase_nx = 2'd0;
            w_wraps_nx = 2'd0;
         end
`else
         if (w_req == r_mode) begin
            w_phase_nx = r_phase + 2'd1;
         end else begin
            w_mode_nx  = w_req;
            w_phase_nx = 2'd0;
         end
`endif
      end
   end

   always_comb begin
      w_lpat = 3'b000;
      w_rpat = 3'b000;
      unique case (r_phase)
         2'd0: begin w_lpat = 3'b000; w_rpat = 3'b000; end
         2'd1: begin w_lpat = 3'b001; w_rpat = 3'b100; end
         2'd2: begin w_lpat = 3'b011; w_rpat = 3'b110; end
         2'd3: begin w_lpat = 3'b111; w_rpat = 3'b111; end
         default: begin w_lpat = 3'b000; w_rpat = 3'b000; end
      endcase
   end

   always_comb begin
      w_led_nx = 10'd0;
      unique case (r_mode)
         M_LEFT:   w_led_nx = {w_lpat, 4'b0000, 3'b000};
         M_RIGHT:  w_led_nx = {3'b000, 4'b0000, w_rpat};
         M_HAZARD: w_led_nx = {{3{r_phase[0]}}, {4{w_b}}, {3{r_phase[0]}}};
         M_BRAKE:  w_led_nx = 10'h3FF;
         M_BLEFT:  w_led_nx = {w_lpat, 4'b1111, 3'b111};
         M_BRIGHT: w_led_nx = {3'b111, 4'b1111, w_rpat};
         default:  w_led_nx = 10'd0;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         r_ledr <= '0;
      else
         r_ledr <= w_led_nx;
   end

   assign LEDR  = r_ledr;
   assign mode  = r_mode;
   assign phase = r_phase;
   assign busy  = r_busy;

endmodule
